sap_clock_ctrl: RTL and testbench
=================================

Name: sap_clock_ctrl

Overview:
Front-end clock/control stage that sits between the board buttons/switches and the SAP-1 core. It synchronizes and debounces the Clear/Start pushbutton, the Manual/Auto switch and the Single-Step pushbutton. It produces a single-cycle CPU step enable, either free-running (auto) or one per press (manual), plus the CPU clear. It also honours the core's HLT signal.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (min 2)
DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept an input change (200 us at 50 MHz)
AUTO_DIV, 25000, base-clock cycles between step enables in auto mode (min 2)

Ports:
sap_base_clock  in  1  system clock
sap_reset_n  in  1  asynchronous active-low reset
sap_ClearStart_pb  in  1  raw button; 0 = clear, 1 = start
sap_ManualAuto_sw  in  1  raw switch; 0 = manual, 1 = auto
sap_SingleStep_pb  in  1  raw button; 1 = pressed
sap_hlt  in  1  core HLT decoded, active-high, synchronous to sap_base_clock
sap_clk_en  out  1  one-cycle CPU step enable
sap_clr  out  1  CPU clear, active-high
sap_auto_mode  out  1  debounced mode (1 = auto)
sap_halted  out  1  high while in HALT state

Behaviour:
- Reset values (async, while sap_reset_n=0):
  - state=CLEAR, sap_clr=1, sap_clk_en=0, sap_auto_mode=0, sap_halted=0.
  - Debounced ClearStart=0, ManualAuto=0, SingleStep=0; synchronizers cleared to the same values.
  - Divider and debounce counters = 0.
- Input path:
  - Each raw input passes through SYNC_STAGES flops, then a debouncer.
  - The debouncer counter increments while the synced input differs from the stable output, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, the stable output takes the input value on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach the stable output.
- FSM states: CLEAR, RUN_AUTO, RUN_MANUAL, HALT.
  - CLEAR: sap_clr=1, no enables. When debounced ClearStart=1, go to RUN_AUTO if debounced mode=1, else RUN_MANUAL.
  - RUN_AUTO: the divider counts 0..AUTO_DIV-1 and sap_clk_en=1 on the cycle the count equals AUTO_DIV-1. The first pulse comes exactly AUTO_DIV cycles after entry.
  - RUN_MANUAL: a debounced SingleStep 0->1 edge gives sap_clk_en=1 on the next cycle, exactly one pulse per press. Holding the button gives no repeat. Release does nothing.
  - Mode change in RUN_AUTO or RUN_MANUAL: moves to the other run state on the cycle after the debounced mode changes. The divider is zeroed on entry to RUN_AUTO. A step edge that falls on the transition cycle is discarded.
  - sap_hlt=1 in any run state: go to HALT next cycle; a same-cycle sap_clk_en is still issued. HALT never pulses and leaves only through CLEAR.
  - Debounced ClearStart=0 in any state: go to CLEAR next cycle. This has priority over hlt, step and mode.
- sap_clr and sap_halted are registered decodes of state.
- sap_clk_en is never high two consecutive cycles (guaranteed because AUTO_DIV>=2).

Optional Feature:
SAP_CLKCTRL_STEP_CNT_EN
- Defined:
  - Adds output sap_step_cnt[15:0].
  - Increments on every sap_clk_en and saturates at 16'hFFFF.
  - Zeroed in CLEAR and on reset.
- Undefined: the port and counter do not exist.

Decomposition:
- Package sap_clk_pkg: state enum typedef (CLEAR, RUN_AUTO, RUN_MANUAL, HALT) and the step counter width constant (16).
- Sub-module sap_debounce (synchronizer plus debouncer, parameterized by SYNC_STAGES and DEBOUNCE_CYCLES, reset value as a parameter), instanced three times.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, AUTO_DIV=4):
- Reset with ClearStart=1 and switch=1 -> sap_clr=1 during reset. sap_clr=0 and state=RUN_AUTO after the ClearStart debounce. Then sap_clk_en pulses every 4 cycles, first pulse 4 cycles after entry.
- Manual mode, SingleStep held high for 20 cycles -> exactly one sap_clk_en. A 5-cycle bounce pulse -> zero pulses.
- 10 clean presses (each 12 cycles high, 12 low) -> exactly 10 pulses.
- Auto running, sap_hlt=1 -> sap_halted=1 next cycle and no further pulses for 100 cycles. ClearStart low then high -> back to RUN_AUTO.
- ClearStart dropped mid-step while a press is being debounced -> sap_clr=1 and no enable. Async reset asserted mid-divide -> all outputs at reset values immediately.
- With SAP_CLKCTRL_STEP_CNT_EN defined: after 10 pulses sap_step_cnt=10; CLEAR forces 0.

Source files
------------

// File: rtl/sap_clk_pkg.sv
// ============================================================================
// Module  : sap_clk_pkg
// Brief   : Shared FSM state encoding and step-counter width for the SAP-1
//           clock/control front end.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sap_clk_pkg;

    typedef enum logic [1:0] {
        CLEAR      = 2'd0,
        RUN_AUTO   = 2'd1,
        RUN_MANUAL = 2'd2,
        HALT       = 2'd3
    } state_t;

    localparam int unsigned c_step_cnt_w = 16;

endpackage : sap_clk_pkg

`default_nettype wire

// File: rtl/sap_debounce.sv
// ============================================================================
// Module  : sap_debounce
// Brief   : Multi-flop synchronizer followed by a counter debouncer. The
//           stable output only follows an input that stays changed for
//           DEBOUNCE_CYCLES consecutive cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sap_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 10000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   w_synced;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign w_synced = sync_q[SYNC_STAGES-1];

    // Any return to the stable level restarts the count, so short glitches
    // never accumulate toward acceptance.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (w_synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == c_cnt_last) begin
            stable_d = w_synced;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            stable_q <= RESET_VAL;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule : sap_debounce

`default_nettype wire

// File: rtl/sap_clock_ctrl.sv
// ============================================================================
// Module  : sap_clock_ctrl
// Brief   : SAP-1 clock/control stage: debounced Clear/Start, Manual/Auto and
//           Single-Step inputs drive a CLEAR/RUN_AUTO/RUN_MANUAL/HALT FSM that
//           issues one-cycle CPU step enables and the CPU clear.
//           Optional step counter output: define SAP_CLKCTRL_STEP_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sap_clock_ctrl
    import sap_clk_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int AUTO_DIV        = 25000
) (
    input  logic sap_base_clock,
    input  logic sap_reset_n,
    input  logic sap_ClearStart_pb,
    input  logic sap_ManualAuto_sw,
    input  logic sap_SingleStep_pb,
    input  logic sap_hlt,
    output logic sap_clk_en,
    output logic sap_clr,
    output logic sap_auto_mode,
    output logic sap_halted
`ifdef SAP_CLKCTRL_STEP_CNT_EN
    ,
    output logic [c_step_cnt_w-1:0] sap_step_cnt
`endif
);

    localparam int c_div_w = $clog2(AUTO_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(AUTO_DIV - 1);

    logic w_cs_db;
    logic w_mode_db;
    logic w_step_db;

    sap_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
    ) u_db_clear_start (
        .clk_i   (sap_base_clock),
        .rst_ni  (sap_reset_n),
        .raw_i   (sap_ClearStart_pb),
        .stable_o(w_cs_db)
    );

    sap_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
    ) u_db_manual_auto (
        .clk_i   (sap_base_clock),
        .rst_ni  (sap_reset_n),
        .raw_i   (sap_ManualAuto_sw),
        .stable_o(w_mode_db)
    );

    sap_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
    ) u_db_single_step (
        .clk_i   (sap_base_clock),
        .rst_ni  (sap_reset_n),
        .raw_i   (sap_SingleStep_pb),
        .stable_o(w_step_db)
    );

    state_t             state_q, state_d;
    logic [c_div_w-1:0] div_q, div_d;
    logic               clk_en_q, clk_en_d;
    logic               clr_q;
    logic               halted_q;
    logic               step_prev_q;
    logic               w_div_wrap;
    logic               w_step_rise;

    assign w_div_wrap  = (div_q == c_div_last);
    assign w_step_rise = w_step_db & ~step_prev_q;

    // Priority inside the run states: clear, then halt, then mode change,
    // then the normal enable source. A mode change swallows that cycle's step.
    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        clk_en_d = 1'b0;
        unique case (state_q)
            CLEAR: begin
                if (w_cs_db) begin
                    state_d = w_mode_db ? RUN_AUTO : RUN_MANUAL;
                end
            end
            RUN_AUTO: begin
                div_d = w_div_wrap ? '0 : div_q + 1'b1;
                if (!w_cs_db) begin
                    state_d = CLEAR;
                end else if (sap_hlt) begin
                    state_d  = HALT;
                    clk_en_d = w_div_wrap;
                end else if (!w_mode_db) begin
                    state_d = RUN_MANUAL;
                end else begin
                    clk_en_d = w_div_wrap;
                end
            end
            RUN_MANUAL: begin
                if (!w_cs_db) begin
                    state_d = CLEAR;
                end else if (sap_hlt) begin
                    state_d  = HALT;
                    clk_en_d = w_step_rise;
                end else if (w_mode_db) begin
                    state_d = RUN_AUTO;
                end else begin
                    clk_en_d = w_step_rise;
                end
            end
            HALT: begin
                if (!w_cs_db) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge sap_base_clock or negedge sap_reset_n) begin
        if (!sap_reset_n) begin
            state_q     <= CLEAR;
            div_q       <= '0;
            clk_en_q    <= 1'b0;
            clr_q       <= 1'b1;
            halted_q    <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            clk_en_q    <= clk_en_d;
            clr_q       <= (state_d == CLEAR);
            halted_q    <= (state_d == HALT);
            step_prev_q <= w_step_db;
        end
    end

    assign sap_clk_en    = clk_en_q;
    assign sap_clr       = clr_q;
    assign sap_halted    = halted_q;
    assign sap_auto_mode = w_mode_db;

`ifdef SAP_CLKCTRL_STEP_CNT_EN
    logic [c_step_cnt_w-1:0] step_cnt_q;

    always_ff @(posedge sap_base_clock or negedge sap_reset_n) begin
        if (!sap_reset_n) begin
            step_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            step_cnt_q <= '0;
        end else if (clk_en_q && (step_cnt_q != '1)) begin
            step_cnt_q <= step_cnt_q + 1'b1;
        end
    end

    assign sap_step_cnt = step_cnt_q;
`endif

endmodule : sap_clock_ctrl

`default_nettype wire

// File: tb/tb_sap_clock_ctrl.sv
// ============================================================================
// Module  : tb_sap_clock_ctrl
// Brief   : Directed, table-driven bench for sap_clock_ctrl (SYNC_STAGES=2,
//           DEBOUNCE_CYCLES=8, AUTO_DIV=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sap_clock_ctrl;

    localparam int SYNC = 2;
    localparam int DB   = 8;
    localparam int DIV  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cs    = 1'b1;
    logic sw    = 1'b1;
    logic step  = 1'b0;
    logic hlt   = 1'b0;

    logic sap_clk_en;
    logic sap_clr;
    logic sap_auto_mode;
    logic sap_halted;
`ifdef SAP_CLKCTRL_STEP_CNT_EN
    logic [15:0] sap_step_cnt;
`endif

    sap_clock_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .AUTO_DIV       (DIV)
    ) dut (
        .sap_base_clock   (clk),
        .sap_reset_n      (rst_n),
        .sap_ClearStart_pb(cs),
        .sap_ManualAuto_sw(sw),
        .sap_SingleStep_pb(step),
        .sap_hlt          (hlt),
        .sap_clk_en       (sap_clk_en),
        .sap_clr          (sap_clr),
        .sap_auto_mode    (sap_auto_mode),
        .sap_halted       (sap_halted)
`ifdef SAP_CLKCTRL_STEP_CNT_EN
        ,
        .sap_step_cnt     (sap_step_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    hi;
        int    lo;
        int    reps;
        int    exp_pulses;
    } vec_t;

    vec_t tbl[5];

    int   total  = 0;
    int   bad    = 0;
    int   pulses = 0;
    int   dbl    = 0;
    logic prev_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; samples outputs 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sap_clk_en === 1'b1) pulses++;
        if (sap_clk_en === 1'b1 && prev_en === 1'b1) dbl++;
        prev_en = sap_clk_en;
    endtask

    task automatic wait_clr(input logic val, input int maxc, input string name);
        int n = 0;
        while (sap_clr !== val && n < maxc) begin
            tick();
            n++;
        end
        check(name, {31'd0, sap_clr}, {31'd0, val});
    endtask

    task automatic press(input int hi, input int lo);
        step = 1'b1;
        repeat (hi) tick();
        step = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"hold20",      20, 30,  1,  1};
        tbl[1] = '{"bounce5",      5, 30,  1,  0};
        tbl[2] = '{"glitch7",      7, 30,  1,  0};
        tbl[3] = '{"press9",       9, 30,  1,  1};
        tbl[4] = '{"ten_presses", 12, 12, 10, 10};

        // Reset held with ClearStart=1 and switch=auto.
        repeat (3) tick();
        check("rst_clr",    {31'd0, sap_clr},       1);
        check("rst_clk_en", {31'd0, sap_clk_en},    0);
        check("rst_auto",   {31'd0, sap_auto_mode}, 0);
        check("rst_halted", {31'd0, sap_halted},    0);
`ifdef SAP_CLKCTRL_STEP_CNT_EN
        check("rst_step_cnt", {16'd0, sap_step_cnt}, 0);
`endif

        // 2 sync + 8 debounce edges, then one more for the FSM to leave CLEAR.
        rst_n = 1'b1;
        repeat (10) tick();
        check("clr_during_debounce", {31'd0, sap_clr}, 1);
        tick();
        check("clr_after_debounce", {31'd0, sap_clr}, 0);
        check("auto_mode_up",       {31'd0, sap_auto_mode}, 1);

        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("auto_en_c%0d", i), {31'd0, sap_clk_en}, (i % DIV == 0) ? 1 : 0);
        end

        // Last sample was a pulse cycle (divider back at 0).
        hlt = 1'b1;
        tick();
        check("halt_next_cycle", {31'd0, sap_halted}, 1);
        check("halt_no_en",      {31'd0, sap_clk_en}, 0);
        hlt = 1'b0;
        pulses = 0;
        repeat (100) tick();
        check("halt_pulses_100", pulses, 0);
        check("halt_sticky",     {31'd0, sap_halted}, 1);

        cs = 1'b0;
        wait_clr(1'b1, 40, "clear_from_halt");
        check("halted_cleared", {31'd0, sap_halted}, 0);
        cs = 1'b1;
        wait_clr(1'b0, 40, "restart_auto");
        check("restart_halted", {31'd0, sap_halted}, 0);
        repeat (3) tick();
        check("restart_no_early_en", {31'd0, sap_clk_en}, 0);
        tick();
        check("restart_first_en", {31'd0, sap_clk_en}, 1);

        sw = 1'b0;
        repeat (30) tick();
        check("manual_mode", {31'd0, sap_auto_mode}, 0);

        for (int v = 0; v < 5; v++) begin
            pulses = 0;
            for (int r = 0; r < tbl[v].reps; r++) press(tbl[v].hi, tbl[v].lo);
            check(tbl[v].name, pulses, tbl[v].exp_pulses);
        end

`ifdef SAP_CLKCTRL_STEP_CNT_EN
        cs = 1'b0;
        wait_clr(1'b1, 40, "cnt_clear");
        tick();
        check("cnt_zero_in_clear", {16'd0, sap_step_cnt}, 0);
        cs = 1'b1;
        wait_clr(1'b0, 40, "cnt_restart");
        for (int r = 0; r < 10; r++) press(12, 12);
        check("cnt_after_10", {16'd0, sap_step_cnt}, 10);
        cs = 1'b0;
        wait_clr(1'b1, 40, "cnt_clear2");
        tick();
        check("cnt_forced_zero", {16'd0, sap_step_cnt}, 0);
        cs = 1'b1;
        wait_clr(1'b0, 40, "cnt_restart2");
`endif

        // ClearStart drop lands on the same edge as a step acceptance.
        pulses = 0;
        step = 1'b1;
        cs   = 1'b0;
        repeat (30) tick();
        check("clear_mid_press_pulses", pulses, 0);
        check("clear_mid_press_clr",    {31'd0, sap_clr}, 1);
        step = 1'b0;
        repeat (20) tick();
        cs = 1'b1;
        wait_clr(1'b0, 40, "manual_restart");
        repeat (20) tick();
        check("manual_restart_pulses", pulses, 0);

        sw = 1'b1;
        repeat (30) tick();
        check("back_to_auto", {31'd0, sap_auto_mode}, 1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clr",    {31'd0, sap_clr},       1);
        check("async_rst_clk_en", {31'd0, sap_clk_en},    0);
        check("async_rst_auto",   {31'd0, sap_auto_mode}, 0);
        check("async_rst_halted", {31'd0, sap_halted},    0);
`ifdef SAP_CLKCTRL_STEP_CNT_EN
        check("async_rst_cnt", {16'd0, sap_step_cnt}, 0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        wait_clr(1'b0, 40, "post_reset_run");
        check("post_reset_auto", {31'd0, sap_auto_mode}, 1);

        check("no_back_to_back_en", dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sap_clock_ctrl

`default_nettype wire
